// File: rtl/mips_pkg.sv
// Shared definitions for the fetch path.
//   RESET_PC_DEF : default reset PC.
//   fetch_state_e: one-bit fetch FSM encoding.
//   OP_*         : opcode constants shared with Control.
//   branch_offset: turns a 16-bit branch immediate into a byte offset.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  typedef enum logic {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;

  // Sign-extend the word offset and scale it to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port.
//   imem_req   : fetch side requests a read
//   imem_addr  : word-aligned read address
//   imem_ready : memory accepts; imem_rdata valid this cycle
//   imem_rdata : instruction word
// master = fetch unit, slave = memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection.
//   pc_i        : current PC
//   instr_idx_i : instr[25:0] (jump index; [15:0] is the branch immediate)
//   beq_i/bne_i/jump_i/jal_i/zero_i : control and ALU flag for this instr
//   pc_plus4_o  : pc + 4 (wraps modulo 2^32)
//   next_pc_o   : jump > taken branch > sequential
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_idx_i,
  input  logic        beq_i,
  input  logic        bne_i,
  input  logic        jump_i,
  input  logic        jal_i,
  input  logic        zero_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);
  logic        taken;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign pc_plus4_o = pc_i + 32'd4;
  // Both branch flags set means "taken on either condition".
  assign taken      = (beq_i & zero_i) | (bne_i & ~zero_i);
  assign br_tgt     = pc_plus4_o + branch_offset(instr_idx_i[15:0]);
  assign j_tgt      = {pc_plus4_o[31:28], instr_idx_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (jump_i | jal_i) next_pc_o = j_tgt;
    else if (taken)     next_pc_o = br_tgt;
  end
endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch: request a word, hold it until the
// downstream stage acks, then advance the PC.
//   clk, reset  : clock, synchronous active-high reset
//   imem        : instruction-memory master port
//   instr       : held instruction (stable while instr_valid)
//   instr_valid : instr ready for decode/execute
//   instr_ack   : downstream done; control/flag inputs valid this cycle
//   BranchEQ/BranchNE/Jump/JumpAndLink/Zero : select next PC on ack
//   pc, pc_plus4: current instruction address and its successor
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master imem,
  output logic [31:0]  instr,
  output logic         instr_valid,
  input  logic         instr_ack,
  input  logic         BranchEQ,
  input  logic         BranchNE,
  input  logic         Jump,
  input  logic         JumpAndLink,
  input  logic         Zero,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4
);
  // Low address bits of the reset vector are dropped so pc stays aligned.
  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc;
  logic         req;

  next_pc_logic u_npc (
    .pc_i        (pc_q),
    .instr_idx_i (instr_q[25:0]),
    .beq_i       (BranchEQ),
    .bne_i       (BranchNE),
    .jump_i      (Jump),
    .jal_i       (JumpAndLink),
    .zero_i      (Zero),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= PC_RST;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // imem_ready only matters in S_REQ, instr_ack only in S_VALID.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    req         = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign pc             = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, instr_ack, beq, bne, jmp, jal, zero;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .imem(bus),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .BranchEQ(beq), .BranchNE(bne), .Jump(jmp), .JumpAndLink(jal), .Zero(zero),
    .pc(pc), .pc_plus4(pc_plus4)
  );

  // Second instance sits at the top of the address space to exercise wrap.
  fetch_unit_if bus2();
  logic [31:0] instr2, pc2, pc_plus4_2;
  logic        iv2, ack2;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFD)) u_wrap (
    .clk(clk), .reset(reset), .imem(bus2),
    .instr(instr2), .instr_valid(iv2), .instr_ack(ack2),
    .BranchEQ(1'b0), .BranchNE(1'b0), .Jump(1'b0), .JumpAndLink(1'b0), .Zero(1'b0),
    .pc(pc2), .pc_plus4(pc_plus4_2)
  );
  assign bus2.imem_rdata = 32'h0000_0000;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  logic [31:0] model_pc, cur_instr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Architectural next-PC rule, written from the instruction semantics.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic b, input logic n, input logic j,
                                           input logic l, input logic z);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (j || l) return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
    if ((b && z) || (n && !z)) begin
      off = $signed(ins[15:0]);
      return seq + off * 4;
    end
    return seq;
  endfunction

  task automatic rand_ctrl();
    beq  = ($urandom % 4) == 0;
    bne  = ($urandom % 4) == 0;
    jmp  = ($urandom % 8) == 0;
    jal  = ($urandom % 8) == 0;
    zero = $urandom_range(0, 1);
  endtask

  // Memory side: optional stall cycles, then deliver val. instr_ack and the
  // control inputs are randomised throughout, since the DUT must ignore them here.
  task automatic fetch_one(input logic [31:0] val, input int stalls);
    int n = 0;
    instr_ack = 1'b0;
    while (bus.imem_req !== 1'b1 && n < 10) begin
      bus.imem_ready = 1'b0;
      step();
      n++;
    end
    if (bus.imem_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL fetch_wait: imem_req never rose, got %b expected 1", bus.imem_req);
      return;
    end
    for (int i = 0; i < stalls; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      instr_ack = $urandom_range(0, 1);
      rand_ctrl();
      step();
      chk("stall_req",   {31'b0, bus.imem_req}, 32'd1);
      chk("stall_addr",  bus.imem_addr, model_pc);
      chk("stall_valid", {31'b0, instr_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = val;
    instr_ack = $urandom_range(0, 1);
    rand_ctrl();
    exp_q.push_back('{pc: model_pc, instr: val});
    cur_instr = val;
    step();
    bus.imem_ready = 1'b0;
    instr_ack = 1'b0;
  endtask

  // Downstream side: hold for some cycles (random imem_ready must be ignored), then ack.
  task automatic ack_one(input logic b, input logic n, input logic j, input logic l,
                         input logic z, input int delay);
    if (instr_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ack_wait: instr_valid got %b expected 1", instr_valid);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      instr_ack = 1'b0;
      rand_ctrl();
      bus.imem_ready = $urandom_range(0, 1);
      bus.imem_rdata = $urandom;
      step();
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_pc",    pc, model_pc);
      chk("hold_instr", instr, cur_instr);
    end
    instr_ack = 1'b1;
    beq = b; bne = n; jmp = j; jal = l; zero = z;
    bus.imem_ready = $urandom_range(0, 1);
    model_pc = ref_next(model_pc, cur_instr, b, n, j, l, z);
    step();
    instr_ack = 1'b0;
    bus.imem_ready = 1'b0;
  endtask

  // Monitor: checks fetch address on each accepted request and the held
  // instruction/pc on each ack against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.imem_req && bus.imem_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fetch_sb: fetch with empty scoreboard at addr %h", bus.imem_addr);
      end else chk("fetch_addr", bus.imem_addr, exp_q[$].pc);
    end
    if (!reset && instr_valid && instr_ack) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack_sb: ack with empty scoreboard, pc %h", pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr",    instr, e.instr);
        chk("sb_pc",       pc, e.pc);
        chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]  ops [9];
    logic [31:0] r;
    ops = '{OP_RTYPE, OP_ADDI, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LUI, OP_ORI, OP_ANDI};
    reset = 1'b1; instr_ack = 1'b0; beq = 0; bne = 0; jmp = 0; jal = 0; zero = 0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    bus2.imem_ready = 1'b0; ack2 = 1'b0;
    step(); step();
    chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
    chk("rst_req",      {31'b0, bus.imem_req}, 32'd1);
    chk("rst_addr",     bus.imem_addr, RST_PC);
    chk("rst_pc_plus4", pc_plus4, 32'h0040_0004);
    chk("rst_instr",    instr, 32'h0);
    chk("wrap_rst_addr",  bus2.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4",  pc_plus4_2, 32'h0000_0000);
    reset = 1'b0;
    model_pc = RST_PC;

    // Wrap instance: one fetch + ack should land at address 0.
    bus2.imem_ready = 1'b1; step();
    bus2.imem_ready = 1'b0; ack2 = 1'b1; step();
    ack2 = 1'b0;
    chk("wrap_pc",  pc2, 32'h0000_0000);
    chk("wrap_req", {31'b0, bus2.imem_req}, 32'd1);

    // First fetch, zero-wait.
    fetch_one(32'h2008_0005, 0);
    chk("first_valid",    {31'b0, instr_valid}, 32'd1);
    chk("first_instr",    instr, 32'h2008_0005);
    chk("first_pc",       pc, 32'h0040_0000);
    chk("first_pc_plus4", pc_plus4, 32'h0040_0004);
    ack_one(0, 0, 0, 0, 0, 1);
    chk("seq_pc",  pc, 32'h0040_0004);
    chk("seq_req", {31'b0, bus.imem_req}, 32'd1);

    repeat (3) begin fetch_one($urandom, 0); ack_one(0, 0, 0, 0, $urandom_range(0, 1), 0); end
    chk("pre_beq_pc", pc, 32'h0040_0010);
    fetch_one(32'h1000_FFFF, 0); ack_one(1, 0, 0, 0, 1, 0);
    chk("beq_taken_pc", pc, 32'h0040_0010);
    fetch_one(32'h1000_FFFF, 0); ack_one(1, 0, 0, 0, 0, 0);
    chk("beq_fall_pc", pc, 32'h0040_0014);

    repeat (3) begin fetch_one($urandom, 0); ack_one(0, 0, 0, 0, $urandom_range(0, 1), 0); end
    chk("pre_jal_pc", pc, 32'h0040_0020);
    fetch_one(32'h0C10_0040, 1);
    chk("jal_pc_plus4", pc_plus4, 32'h0040_0024);
    ack_one(0, 0, 0, 1, 0, 2);
    chk("jal_pc", pc, 32'h0040_0100);

    // Three-cycle memory stall.
    fetch_one(32'h3C01_1234, 3);
    chk("stall_capture_valid", {31'b0, instr_valid}, 32'd1);
    chk("stall_capture_instr", instr, 32'h3C01_1234);

    // Reset with a pending jump ack must win.
    reset = 1'b1; instr_ack = 1'b1; jmp = 1'b1;
    step();
    reset = 1'b0; instr_ack = 1'b0; jmp = 1'b0;
    chk("midrst_pc",    pc, RST_PC);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("midrst_instr", instr, 32'h0);
    exp_q.delete();
    model_pc = RST_PC;

    // Randomised traffic.
    repeat (300) begin
      r = $urandom;
      fetch_one({ops[$urandom_range(0, 8)], r[25:0]},
                ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0);
      ack_one(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
              ($urandom % 8) == 0, $urandom_range(0, 1), int'($urandom_range(0, 2)));
    end
    step();
    chk("sb_drained", exp_q.size(), 32'd0);
    chk("final_pc", pc, model_pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
